// File: rtl/neighbor_output_dispatcher.sv
// Neighbor-exchange transmit side: classifies halo products by direction,
// rebases coordinates into the neighbor tile and queues them per direction.
module neighbor_output_dispatcher #(
  parameter int TILE_SIZE     = 256,
  parameter int PRODUCT_COUNT = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int CW            = $clog2(TILE_SIZE)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [PRODUCT_COUNT-1:0]            product_valid,
  input  logic [PRODUCT_COUNT-1:0][7:0]       product_value,
  input  logic [PRODUCT_COUNT-1:0][CW+1:0]    product_row,
  input  logic [PRODUCT_COUNT-1:0][CW+1:0]    product_column,
  output logic                                product_ready,
  input  logic [7:0]                          neighbor_ready,
  output logic [7:0][7:0]                     neighbor_output_value,
  output logic [7:0][CW-1:0]                  neighbor_output_row,
  output logic [7:0][CW-1:0]                  neighbor_output_column,
  output logic [7:0]                          neighbor_output_write_enable,
  output logic                                dispatch_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] ROOM_LIM =
    NW'(FIFO_DEPTH - PRODUCT_COUNT);

  typedef struct packed {
    logic [7:0]    value;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } entry_t;

  entry_t        mem_q    [8][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [8];
  logic [AW-1:0] wr_ptr_d [8];
  logic [AW-1:0] rd_ptr_q [8];
  logic [AW-1:0] rd_ptr_d [8];
  logic [NW-1:0] count_q  [8];
  logic [NW-1:0] count_d  [8];
  logic [NW-1:0] enq_cnt  [8];
  entry_t        out_q    [8];
  logic [7:0]    we_q;
  logic [7:0]    deq;
  logic [7:0]    nonempty;
  logic          accept;

  logic [PRODUCT_COUNT-1:0] r_neg, r_hi, r_in;
  logic [PRODUCT_COUNT-1:0] c_neg, c_hi, c_in;
  logic [PRODUCT_COUNT-1:0] lane_halo;
  logic [PRODUCT_COUNT-1:0] lane_we;
  logic [2:0]    lane_dir  [PRODUCT_COUNT];
  logic [NW-1:0] lane_off  [PRODUCT_COUNT];
  logic [AW-1:0] lane_slot [PRODUCT_COUNT];
  entry_t        lane_ent  [PRODUCT_COUNT];

  // Top two coordinate bits: sign -> below 0, next -> at or past TILE_SIZE
  always_comb begin
    for (int l = 0; l < PRODUCT_COUNT; l++) begin
      r_neg[l] = product_row[l][CW+1];
      r_hi[l]  = ~product_row[l][CW+1] & product_row[l][CW];
      r_in[l]  = ~product_row[l][CW+1] & ~product_row[l][CW];
      c_neg[l] = product_column[l][CW+1];
      c_hi[l]  = ~product_column[l][CW+1] & product_column[l][CW];
      c_in[l]  = ~product_column[l][CW+1] & ~product_column[l][CW];
    end
  end

  always_comb begin
    for (int l = 0; l < PRODUCT_COUNT; l++) begin
      lane_dir[l]  = 3'd0;
      lane_halo[l] = 1'b1;
      unique case (1'b1)
        r_neg[l] & c_in[l]:  lane_dir[l] = 3'd0;
        r_neg[l] & c_hi[l]:  lane_dir[l] = 3'd1;
        r_in[l]  & c_hi[l]:  lane_dir[l] = 3'd2;
        r_hi[l]  & c_hi[l]:  lane_dir[l] = 3'd3;
        r_hi[l]  & c_in[l]:  lane_dir[l] = 3'd4;
        r_hi[l]  & c_neg[l]: lane_dir[l] = 3'd5;
        r_in[l]  & c_neg[l]: lane_dir[l] = 3'd6;
        r_neg[l] & c_neg[l]: lane_dir[l] = 3'd7;
        default:             lane_halo[l] = 1'b0;
      endcase
      lane_ent[l].value = product_value[l];
      lane_ent[l].row   = product_row[l][CW-1:0];
      lane_ent[l].col   = product_column[l][CW-1:0];
    end
  end

  always_comb begin
    product_ready = 1'b1;
    for (int d = 0; d < 8; d++) begin
      if (count_q[d] > ROOM_LIM) product_ready = 1'b0;
    end
  end

  assign accept = product_ready & (|product_valid);

  // Same-direction lanes take consecutive slots in ascending lane order
  always_comb begin
    for (int d = 0; d < 8; d++) enq_cnt[d] = '0;
    for (int l = 0; l < PRODUCT_COUNT; l++) begin
      lane_we[l]  = accept & product_valid[l] & lane_halo[l];
      lane_off[l] = '0;
      for (int j = 0; j < l; j++) begin
        if (lane_we[j] && (lane_dir[j] == lane_dir[l]))
          lane_off[l] = lane_off[l] + NW'(1);
      end
      lane_slot[l] = wr_ptr_q[lane_dir[l]] + lane_off[l][AW-1:0];
      if (lane_we[l])
        enq_cnt[lane_dir[l]] = enq_cnt[lane_dir[l]] + NW'(1);
    end
  end

  always_comb begin
    for (int d = 0; d < 8; d++) begin
      nonempty[d] = (count_q[d] != '0);
      deq[d]      = nonempty[d] & neighbor_ready[d];
      wr_ptr_d[d] = wr_ptr_q[d] + enq_cnt[d][AW-1:0];
      rd_ptr_d[d] = rd_ptr_q[d] + AW'(deq[d]);
      count_d[d]  = count_q[d] + enq_cnt[d] - NW'(deq[d]);
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < PRODUCT_COUNT; l++) begin
      if (lane_we[l])
        mem_q[lane_dir[l]][lane_slot[l]] <= lane_ent[l];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= '0;
      for (int d = 0; d < 8; d++) begin
        wr_ptr_q[d] <= '0;
        rd_ptr_q[d] <= '0;
        count_q[d]  <= '0;
        out_q[d]    <= '0;
      end
    end else begin
      we_q <= deq;
      for (int d = 0; d < 8; d++) begin
        wr_ptr_q[d] <= wr_ptr_d[d];
        rd_ptr_q[d] <= rd_ptr_d[d];
        count_q[d]  <= count_d[d];
        if (deq[d]) out_q[d] <= mem_q[d][rd_ptr_q[d]];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 8; d++) begin
      neighbor_output_value[d]  = out_q[d].value;
      neighbor_output_row[d]    = out_q[d].row;
      neighbor_output_column[d] = out_q[d].col;
    end
  end

  assign neighbor_output_write_enable = we_q;
  assign dispatch_busy = (|nonempty) | (|we_q);

endmodule

// File: doc/neighbor_output_dispatcher.md
Name: neighbor_output_dispatcher

Overview:
- Transmit side of the neighbor-exchange interface. Takes up to PRODUCT_COUNT partial products per cycle whose coordinates fall outside the local tile (halo).
- Classifies each product into one of 8 neighbor directions, translates its coordinates into that neighbor's tile frame, and queues it in a per-direction FIFO.
- Emits at most one value/row/column/write-enable per direction per cycle. These outputs drive the neighbor PE's 8-lane neighbor-input port.

Parameters:
TILE_SIZE, 256, tile edge length; must be a power of 2; CW = $clog2(TILE_SIZE)
PRODUCT_COUNT, 4, product lanes accepted per cycle
FIFO_DEPTH, 8, entries per direction FIFO; must be a power of 2 and >= PRODUCT_COUNT

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
product_valid  input  [PRODUCT_COUNT]  per-lane product valid
product_value  input  8 x [PRODUCT_COUNT]  product data
product_row  input  signed CW+2 x [PRODUCT_COUNT]  row in local frame; legal range -TILE_SIZE..2*TILE_SIZE-1
product_column  input  signed CW+2 x [PRODUCT_COUNT]  column in local frame; same legal range
product_ready  output  1  the whole lane group is accepted in a cycle where any product_valid=1 and product_ready=1
neighbor_ready  input  8  per-direction downstream ready
neighbor_output_value  output  8 x [8]  value to neighbor d
neighbor_output_row  output  CW x [8]  row in neighbor's frame
neighbor_output_column  output  CW x [8]  column in neighbor's frame
neighbor_output_write_enable  output  8  one-cycle strobe per direction
dispatch_busy  output  1  any FIFO non-empty or any write_enable high

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-high on port reset.
- While reset=1 at a posedge:
  - All FIFOs are emptied (pointers and counts cleared).
  - All neighbor_output_* are 0.
  - dispatch_busy=0.
  - Queued data is discarded; asserting reset mid-drain is legal.
- product_ready is combinational from FIFO counts: 1 iff every direction FIFO has free entries >= PRODUCT_COUNT. After reset it is 1.
- Direction index d:
  - 0=N (row<0, col in tile)
  - 1=NE (row<0, col>=TILE_SIZE)
  - 2=E (col>=TILE_SIZE, row in tile)
  - 3=SE (both >= TILE_SIZE)
  - 4=S (row>=TILE_SIZE, col in tile)
  - 5=SW (row>=TILE_SIZE, col<0)
  - 6=W (col<0, row in tile)
  - 7=NW (both <0)
- Corner products go to the diagonal direction only; they are never duplicated.
- In-tile products (0 <= row, col < TILE_SIZE) are accepted and silently dropped.
- Coordinate translation: neighbor row = low CW bits of row; neighbor column = low CW bits of column. This equals a ±TILE_SIZE wrap. Out-of-legal-range inputs are undefined.
- Enqueue on accept:
  - Each valid halo lane is written into FIFO[d].
  - Multiple lanes targeting the same d in one cycle are enqueued in ascending lane order, all in that cycle.
  - Per-direction order is FIFO across cycles.
- Dequeue, per direction d, each posedge:
  - If FIFO[d] is non-empty and neighbor_ready[d]=1: pop the head into the registered outputs value/row/column[d] and set write_enable[d]=1.
  - Otherwise write_enable[d]=0, and value/row/column[d] hold their last value.
  - Directions are independent; there is no cross-direction arbitration.
- Simultaneous enqueue and dequeue on the same FIFO in one cycle is legal. The count update is the net of both.
- Latency: a product accepted in cycle c appears on the outputs in cycle c+2 if FIFO[d] was empty and neighbor_ready[d]=1 in cycle c+1.
- Throughput: 1 entry per direction per cycle.
- No drops: overflow is impossible by construction of product_ready.
- dispatch_busy is combinational: OR of all FIFO non-empty flags and all write_enable bits.

Test Plan:
- Configuration for all scenarios: TILE_SIZE=256, PRODUCT_COUNT=4, FIFO_DEPTH=8.
- Reset (hold reset 2 cycles) -> all write_enable=0, outputs 0, product_ready=1, dispatch_busy=0; also after reset asserted mid-drain, no stale entries emerge.
- Lane0 valid, row=-1, col=5, value=0x3A; all neighbor_ready=1 -> in cycle c+2 only write_enable[0]=1, row=255, col=5, value=0x3A, for exactly one cycle; then busy=0.
- Lane2 row=256, col=-2, value=0x7F -> write_enable[5] (SW) with row=0, col=254; lane1 row=-3, col=300 in the same cycle -> write_enable[1] (NE) with row=253, col=44 in the same output cycle.
- Four lanes row=10, col=256, values 1,2,3,4 -> E direction (2) emits values 1,2,3,4 in 4 consecutive cycles, row=10, col=0.
- neighbor_ready[2]=0; feed 4 east products per cycle -> accepted in 2 cycles, then product_ready=0. Raise ready -> 8 values drain in order; product_ready returns to 1 once FIFO[2] free >= 4.
- Lane3 row=3, col=3 (in tile) -> accepted, no write_enable ever, dispatch_busy stays 0.
